// File: rtl/cache_ctrl_if.sv
// CPU-side and memory-side handshake bundle for the cache controller.
// The controller binds to the slave modport; the CPU/memory environment binds to master.
interface cache_ctrl_if #(
  parameter int unsigned ADDR_W = 16
);
  logic              cpu_req_valid;
  logic              cpu_req_we;
  logic [ADDR_W-1:0] cpu_req_addr;
  logic [31:0]       cpu_req_wdata;
  logic              cpu_req_ready;
  logic              cpu_resp_valid;
  logic [31:0]       cpu_resp_rdata;

  logic              mem_req_valid;
  logic              mem_req_we;
  logic [ADDR_W-1:0] mem_req_addr;
  logic [31:0]       mem_req_wdata;
  logic              mem_req_ready;
  logic              mem_rvalid;
  logic [31:0]       mem_rdata;

  modport slave (
    input  cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    output cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    output mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    input  mem_req_ready, mem_rvalid, mem_rdata
  );

  modport master (
    output cpu_req_valid, cpu_req_we, cpu_req_addr, cpu_req_wdata,
    input  cpu_req_ready, cpu_resp_valid, cpu_resp_rdata,
    input  mem_req_valid, mem_req_we, mem_req_addr, mem_req_wdata,
    output mem_req_ready, mem_rvalid, mem_rdata
  );
endinterface

// File: rtl/cache_ctrl.sv
// Direct-mapped, write-back, write-allocate cache controller with word-wide
// CPU port and a word-serial writeback / block-refill memory port.
module cache_ctrl #(
  parameter int unsigned ADDR_W   = 16,
  parameter int unsigned INDEX_W  = 5,
  parameter int unsigned OFFSET_W = 5
) (
  input  logic         clk,
  input  logic         rst_n,
  cache_ctrl_if.slave  bus
);
  localparam int unsigned TAG_W  = ADDR_W - INDEX_W - OFFSET_W;
  localparam int unsigned WORD_W = OFFSET_W - 2;
  localparam int unsigned LINES  = 1 << INDEX_W;
  localparam int unsigned WORDS  = 1 << WORD_W;

  typedef enum logic [2:0] {
    IDLE,
    COMPARE,
    WRITEBACK,
    REQ_FILL,
    FILL
  } state_t;

  state_t state, state_nxt;

  logic [LINES-1:0] valid;
  logic [LINES-1:0] dirty;
  logic [TAG_W-1:0] tag_mem  [LINES];
  logic [31:0]      data_mem [LINES][WORDS];

  logic [ADDR_W-1:2] req_addr;
  logic              req_we;
  logic [31:0]       req_wdata;
  logic [WORD_W-1:0] cnt;

  logic [TAG_W-1:0]   req_tag;
  logic [INDEX_W-1:0] req_idx;
  logic [WORD_W-1:0]  req_word;
  logic               hit;
  logic               cnt_last;

  assign req_tag  = req_addr[ADDR_W-1 -: TAG_W];
  assign req_idx  = req_addr[OFFSET_W +: INDEX_W];
  assign req_word = req_addr[2 +: WORD_W];
  assign hit      = valid[req_idx] && (tag_mem[req_idx] == req_tag);
  assign cnt_last = (cnt == '1);

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      cnt       <= '0;
      valid     <= '0;
      dirty     <= '0;
      req_addr  <= '0;
      req_we    <= 1'b0;
      req_wdata <= '0;
    end else begin
      state <= state_nxt;
      if (state == IDLE && bus.cpu_req_valid) begin
        req_addr  <= bus.cpu_req_addr[ADDR_W-1:2];
        req_we    <= bus.cpu_req_we;
        req_wdata <= bus.cpu_req_wdata;
      end
      case (state)
        COMPARE: begin
          if (hit && req_we) dirty[req_idx] <= 1'b1;
        end
        WRITEBACK: begin
          // cnt wraps back to zero after the last word, ready for the refill
          if (bus.mem_req_ready) cnt <= cnt + 1'b1;
        end
        REQ_FILL: begin
          // Line is dropped before refill so an aborted fill can never hit
          if (bus.mem_req_ready) begin
            valid[req_idx] <= 1'b0;
            dirty[req_idx] <= 1'b0;
          end
        end
        FILL: begin
          if (bus.mem_rvalid) begin
            cnt <= cnt + 1'b1;
            if (cnt_last) begin
              valid[req_idx] <= 1'b1;
              dirty[req_idx] <= 1'b0;
            end
          end
        end
        default: ;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (state == COMPARE && hit && req_we)
      data_mem[req_idx][req_word] <= req_wdata;
    if (state == FILL && bus.mem_rvalid) begin
      data_mem[req_idx][cnt] <= bus.mem_rdata;
      if (cnt_last) tag_mem[req_idx] <= req_tag;
    end
  end

  always_comb begin
    state_nxt          = state;
    bus.cpu_req_ready  = 1'b0;
    bus.cpu_resp_valid = 1'b0;
    bus.cpu_resp_rdata = '0;
    bus.mem_req_valid  = 1'b0;
    bus.mem_req_we     = 1'b0;
    bus.mem_req_addr   = '0;
    bus.mem_req_wdata  = '0;
    case (state)
      IDLE: begin
        bus.cpu_req_ready = 1'b1;
        if (bus.cpu_req_valid) state_nxt = COMPARE;
      end
      COMPARE: begin
        if (hit) begin
          bus.cpu_resp_valid = 1'b1;
          if (!req_we) bus.cpu_resp_rdata = data_mem[req_idx][req_word];
          state_nxt = IDLE;
        end else if (valid[req_idx] && dirty[req_idx]) begin
          state_nxt = WRITEBACK;
        end else begin
          state_nxt = REQ_FILL;
        end
      end
      WRITEBACK: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_we    = 1'b1;
        bus.mem_req_addr  = {tag_mem[req_idx], req_idx, cnt, 2'b00};
        bus.mem_req_wdata = data_mem[req_idx][cnt];
        if (bus.mem_req_ready && cnt_last) state_nxt = REQ_FILL;
      end
      REQ_FILL: begin
        bus.mem_req_valid = 1'b1;
        bus.mem_req_addr  = {req_tag, req_idx, {OFFSET_W{1'b0}}};
        if (bus.mem_req_ready) state_nxt = FILL;
      end
      FILL: begin
        if (bus.mem_rvalid && cnt_last) state_nxt = COMPARE;
      end
      default: state_nxt = IDLE;
    endcase
  end
endmodule
